// File: rtl/seq_det_ctrl.sv
// Serial 4-bit pattern detector fed by a byte stream: bytes are serialized MSB first,
// overlapping matches are pulsed and counted, and a sticky threshold flag stops intake.
module seq_det_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [3:0]       cfg_pattern,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             thresh_hit,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [2:0]       SEEN_MAX = 3'd4;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q;
  logic [7:0]       data_q;
  logic [2:0]       hist_q;
  logic [2:0]       seen_q;
  logic             match_q;
  logic [CNT_W-1:0] cnt_q;
  logic             thr_q;

  logic             hs;
  logic             cur_bit;
  logic             shift_c;
  logic             match_c;
  logic [CNT_W-1:0] cnt_inc;

  // Ready on the last bit too, so bytes can stream without a bubble.
  assign s_ready = ~rst & en & ~thr_q & ~clear &
                   ((state_q == IDLE) | ((state_q == SHIFT) & (idx_q == 3'd0)));
  assign hs      = s_valid & s_ready;
  assign cur_bit = data_q[idx_q];
  assign shift_c = (state_q == SHIFT) & ~clear;
  // Window counts the current bit, so three earlier bits suffice.
  assign match_c = shift_c & (seen_q >= 3'd3) & ({hist_q, cur_bit} == cfg_pattern);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear)                                       state_d = IDLE;
    else if (hs)                                     state_d = SHIFT;
    else if ((state_q == SHIFT) && (idx_q == 3'd0))  state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= 3'd0;
      data_q  <= 8'd0;
      hist_q  <= 3'd0;
      seen_q  <= 3'd0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      thr_q   <= 1'b0;
    end else if (clear) begin
      idx_q   <= 3'd0;
      data_q  <= 8'd0;
      hist_q  <= 3'd0;
      seen_q  <= 3'd0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      thr_q   <= 1'b0;
    end else begin
      match_q <= match_c;
      if (shift_c) begin
        hist_q <= {hist_q[1:0], cur_bit};
        if (seen_q != SEEN_MAX) seen_q <= seen_q + 3'd1;
        if (idx_q != 3'd0)      idx_q  <= idx_q - 3'd1;
      end
      if (hs) begin
        data_q <= s_data;
        idx_q  <= 3'd7;
      end
      if (match_c) begin
        cnt_q <= cnt_inc;
        if ((cfg_thresh != '0) && (cnt_inc == cfg_thresh)) thr_q <= 1'b1;
      end
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign thresh_hit  = thr_q;
  assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a bit-queue model.
module tb_seq_det_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, en, clear, s_valid;
  logic [3:0]       cfg_pattern;
  logic [CNT_W-1:0] cfg_thresh;
  logic [7:0]       s_data;
  logic             s_ready, match, thresh_hit, busy;
  logic [CNT_W-1:0] match_count;

  seq_det_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .cfg_pattern(cfg_pattern), .cfg_thresh(cfg_thresh),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .match(match), .match_count(match_count),
    .thresh_hit(thresh_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: bits waiting to be serialized, and the most recent consumed bits since clear.
  bit pend_q[$];
  bit recent_q[$];
  int m_cnt;
  bit m_thr, m_match;

  int  pulses, nbusy, nready;
  bit  last_ready;
  logic [7:0] mask;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return en && !m_thr && !clear && (pend_q.size() <= 1);
  endfunction

  task automatic m_reset();
    pend_q.delete();
    recent_q.delete();
    m_cnt = 0; m_thr = 0; m_match = 0;
  endtask

  task automatic m_edge(input bit hs);
    bit b;
    if (clear) begin
      m_reset();
      return;
    end
    m_match = 0;
    if (pend_q.size() > 0) begin
      b = pend_q.pop_front();
      recent_q.push_back(b);
      if (recent_q.size() > 4) void'(recent_q.pop_front());
      if (recent_q.size() == 4 &&
          {recent_q[0], recent_q[1], recent_q[2], recent_q[3]} == cfg_pattern) begin
        m_match = 1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (cfg_thresh != 0 && m_cnt == int'(cfg_thresh)) m_thr = 1;
      end
    end
    if (hs) for (int i = 7; i >= 0; i--) pend_q.push_back(s_data[i]);
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit e, input bit c, input bit v, input logic [7:0] d);
    bit hs;
    en = e; clear = c; s_valid = v; s_data = d;
    #1;
    last_ready = s_ready;
    chk("s_ready", 32'(s_ready), 32'(m_ready()));
    hs = v && m_ready();
    @(posedge clk);
    m_edge(hs);
    @(negedge clk);
    chk("busy",        32'(busy),        32'(pend_q.size() > 0));
    chk("match",       32'(match),       32'(m_match));
    chk("match_count", 32'(match_count), 32'(m_cnt));
    chk("thresh_hit",  32'(thresh_hit),  32'(m_thr));
    if (match) pulses++;
    if (busy)  nbusy++;
    if (last_ready) nready++;
  endtask

  task automatic setup(input logic [3:0] pat, input logic [CNT_W-1:0] thr);
    cfg_pattern = pat; cfg_thresh = thr;
    step(1, 1, 0, 8'h00);
    pulses = 0; nbusy = 0; nready = 0; mask = 8'h00;
  endtask

  // Sends one byte and collects per-bit match positions into mask.
  task automatic send_byte(input logic [7:0] d);
    step(1, 0, 1, d);
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 0, 8'h00);
      mask[k] = match;
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, 32'(s_ready),     32'd0);
    chk({tag, "_busy"},  32'(busy),        32'd0);
    chk({tag, "_match"}, 32'(match),       32'd0);
    chk({tag, "_cnt"},   32'(match_count), 32'd0);
    chk({tag, "_thr"},   32'(thresh_hit),  32'd0);
  endtask

  initial begin
    rst = 1; en = 1; clear = 0; s_valid = 1; s_data = 8'hA5;
    cfg_pattern = 4'b0010; cfg_thresh = '0;
    m_reset();
    #3;
    chk_zero_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst = 0; s_valid = 0;

    // Overlap inside one byte.
    setup(4'b0010, '0);
    send_byte(8'h12);
    chk("ovl_mask", 32'(mask), 32'h90);
    chk("ovl_cnt",  32'(match_count), 32'd2);
    chk("ovl_busy", 32'(nbusy), 32'd8);

    // Match spanning a byte boundary, no bubble between bytes.
    setup(4'b0010, '0);
    step(1, 0, 1, 8'h01);
    for (int k = 0; k < 7; k++) step(1, 0, 0, 8'h00);
    step(1, 0, 1, 8'h00);
    chk("xb_ready_last_bit", 32'(last_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 0, 8'h00);
      mask[k] = match;
    end
    chk("xb_mask",   32'(mask),   32'h01);
    chk("xb_pulses", 32'(pulses), 32'd1);
    chk("xb_busy",   32'(nbusy),  32'd16);

    // Threshold stops intake after the byte in progress.
    setup(4'b0000, CNT_W'(3));
    step(1, 0, 1, 8'h00);
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 1, 8'h55);
      if (thresh_hit && mask[0] == 1'b0) begin
        mask[0] = 1'b1;
        chk("thr_on_third", 32'(pulses), 32'd3);
      end
    end
    chk("thr_pulses", 32'(pulses), 32'd5);
    chk("thr_cnt",    32'(match_count), 32'd5);
    chk("thr_flag",   32'(thresh_hit), 32'd1);
    nready = 0;
    for (int k = 0; k < 4; k++) step(1, 0, 1, 8'h55);
    chk("thr_no_ready", 32'(nready), 32'd0);

    // Counter saturation with continuous 0xFF.
    setup(4'b1111, '0);
    for (int k = 0; k < 33; k++) step(1, 0, 1, 8'hFF);
    chk("sat_cnt",    32'(match_count), 32'd15);
    chk("sat_pulses", 32'(pulses), 32'd29);

    // Clear mid-byte, then fresh history is required.
    setup(4'b0000, CNT_W'(1));
    step(1, 0, 1, 8'h00);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 8'h00);
    chk("clr_pre_thr", 32'(thresh_hit), 32'd1);
    step(1, 1, 0, 8'h00);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_cnt",  32'(match_count), 32'd0);
    chk("clr_thr",  32'(thresh_hit), 32'd0);
    send_byte(8'h00);
    chk("clr_fresh_mask", 32'(mask), 32'hF8);

    // Same with asynchronous reset between edges.
    setup(4'b0000, CNT_W'(1));
    step(1, 0, 1, 8'h00);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 8'h00);
    #2 rst = 1;
    #1 chk_zero_outputs("rst_mid");
    m_reset();
    @(negedge clk);
    rst = 0;
    send_byte(8'h00);
    chk("rst_fresh_mask", 32'(mask), 32'hF8);

    // en drop mid-byte.
    setup(4'b0000, '0);
    step(1, 0, 1, 8'h00);
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    nready = 0;
    for (int k = 0; k < 8; k++) step(0, 0, 1, 8'h3C);
    chk("en_cnt",      32'(match_count), 32'd5);
    chk("en_no_ready", 32'(nready), 32'd0);
    step(1, 0, 1, 8'h3C);
    chk("en_ready_back", 32'(last_ready), 32'd1);

    // Random traffic.
    setup(4'($urandom), '0);
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] d;
      if ($urandom_range(15) == 0) cfg_pattern = 4'($urandom);
      if ($urandom_range(63) == 0)
        cfg_thresh = ($urandom_range(1) == 0) ? '0 : CNT_W'($urandom);
      case ($urandom_range(3))
        0:       d = 8'h00;
        1:       d = 8'hFF;
        default: d = 8'($urandom);
      endcase
      step($urandom_range(7) != 0, $urandom_range(49) == 0, $urandom_range(3) != 0, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
